// File: rtl/lc3_execute.sv
// rtl/lc3_execute.sv - LC3 execute stage: ALU, address generation, operand bypass, result registers
//
// Purpose:
//   Takes the decode bundle (E_control, W_control, Mem_control, IR, npc_out) plus
//   register-file read data, computes the ALU result and the PC/base-relative
//   address, and registers everything for the memory-access / writeback stages.
//   Also drives the register-file source addresses combinationally.
//
// Configuration macro:
//   EXECUTE_BYPASS_EN  defined     -> operands may be forwarded from the registered
//                                     aluout or from Mem_Bypass_Val
//                      not defined -> operands are VSR1/VSR2 only; bypass inputs ignored
//
// Ports:
//   clock, reset (sync, active-high), enable_execute (load enable)
//   E_control {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_control, Mem_control, IR, npc_out        decode bundle
//   VSR1, VSR2                                 register-file read data
//   bypass_alu_1/2, bypass_mem_1/2, Mem_Bypass_Val   operand forwarding controls/data
//   aluout, pcout, M_Data, dr, W_Control_out, Mem_Control_out, IR_Exec, NZP   registered
//   sr1, sr2                                   combinational source register addresses

module lc3_execute #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [5:0]    E_control,
  input  logic [1:0]    W_control,
  input  logic          Mem_control,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] npc_out,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] pcout,
  output logic [DW-1:0] M_Data,
  output logic [2:0]    dr,
  output logic [1:0]    W_Control_out,
  output logic          Mem_Control_out,
  output logic [DW-1:0] IR_Exec,
  output logic [2:0]    NZP,
  output logic [2:0]    sr1,
  output logic [2:0]    sr2
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [3:0] opcode;

  assign alu_control = E_control[5:4];
  assign pcselect1   = E_control[3:2];
  assign pcselect2   = E_control[1];
  assign op2select   = E_control[0];
  assign opcode      = IR[15:12];

  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] pcout_q, pcout_d;
  logic [DW-1:0] mdata_q, mdata_d;
  logic [2:0]    dr_q, dr_d;
  logic [1:0]    wctl_q;
  logic          memctl_q;
  logic [DW-1:0] ir_q;
  logic [2:0]    nzp_q, nzp_d;

  // Stores read the data register through the second port, so sr2 follows IR[11:9].
  assign sr1 = IR[8:6];
  assign sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? IR[11:9] : IR[2:0];

  logic [DW-1:0] operand1, operand2;

`ifdef EXECUTE_BYPASS_EN
  // ALU forwarding is the younger value, so it wins over the memory-stage value.
  always_comb begin
    operand1 = VSR1;
    if (bypass_alu_1)      operand1 = aluout_q;
    else if (bypass_mem_1) operand1 = Mem_Bypass_Val;
    operand2 = VSR2;
    if (bypass_alu_2)      operand2 = aluout_q;
    else if (bypass_mem_2) operand2 = Mem_Bypass_Val;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, Mem_Bypass_Val};
  assign operand1 = VSR1;
  assign operand2 = VSR2;
`endif

  logic [DW-1:0] op2, alu_res, offset, base, addr;

  assign op2 = op2select ? operand2 : {{(DW-5){IR[4]}}, IR[4:0]};

  always_comb begin
    alu_res = '0;
    case (alu_control)
      2'b00:   alu_res = operand1 + op2;
      2'b01:   alu_res = operand1 & op2;
      2'b10:   alu_res = ~operand1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    offset = '0;
    case (pcselect1)
      2'b00:   offset = {{(DW-11){IR[10]}}, IR[10:0]};
      2'b01:   offset = {{(DW-9){IR[8]}}, IR[8:0]};
      2'b10:   offset = {{(DW-6){IR[5]}}, IR[5:0]};
      default: offset = '0;
    endcase
  end

  assign base = pcselect2 ? npc_out : operand1;
  assign addr = base + offset;

  always_comb begin
    aluout_d = aluout_q;
    pcout_d  = addr;
    mdata_d  = operand2;
    dr_d     = 3'b000;
    nzp_d    = 3'b000;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT: begin
        aluout_d = alu_res;
        dr_d     = IR[11:9];
      end
      OP_LEA: begin
        aluout_d = addr;
        dr_d     = IR[11:9];
      end
      OP_LD, OP_LDR, OP_LDI: dr_d = IR[11:9];
      OP_BR:  nzp_d = IR[11:9];
      OP_JMP: nzp_d = 3'b111;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aluout_q <= '0;
      pcout_q  <= '0;
      mdata_q  <= '0;
      dr_q     <= '0;
      wctl_q   <= '0;
      memctl_q <= 1'b0;
      ir_q     <= '0;
      nzp_q    <= '0;
    end else if (enable_execute) begin
      aluout_q <= aluout_d;
      pcout_q  <= pcout_d;
      mdata_q  <= mdata_d;
      dr_q     <= dr_d;
      wctl_q   <= W_control;
      memctl_q <= Mem_control;
      ir_q     <= IR;
      nzp_q    <= nzp_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = mdata_q;
  assign dr              = dr_q;
  assign W_Control_out   = wctl_q;
  assign Mem_Control_out = memctl_q;
  assign IR_Exec         = ir_q;
  assign NZP             = nzp_q;

endmodule
